color_sequencer: RTL
====================

COLOR_SEQUENCER -- requirements
Module: color_sequencer

Interface
REQ-001 SHALL have parameter AUTO_FRAMES, default 60, frames between auto-cycle advances (range 2..255).
REQ-002 SHALL have parameter FLASH_FRAMES, default 8, frames the corner-hit flash is shown (range 1..255).
REQ-003 SHALL have port clk  input  1  system clock; the block's only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-006 SHALL have port bounce_x  input  1  one-cycle pulse, ball hit left/right wall.
REQ-007 SHALL have port bounce_y  input  1  one-cycle pulse, ball hit top/bottom wall.
REQ-008 SHALL have port auto_en  input  1  level, enables periodic colour advance.
REQ-009 SHALL have port hold  input  1  level, freezes all colour changes.
REQ-010 SHALL have port color_index  output  3  registered palette index to the palette lookup.
REQ-011 SHALL have port changed  output  1  one-cycle pulse when color_index takes a new value.

Function
REQ-012 SHALL keep two pending flags, pend_x and pend_y, set by bounce_x and bounce_y, cleared only at frame_start processing or reset.
REQ-013 SHALL evaluate a bounce asserted in the same cycle as frame_start as pending for that frame_start.
REQ-014 SHALL keep a 3-bit base index; advance = base+1 mod 8 (7 wraps to 0).
REQ-015 SHALL implement states NORMAL and FLASH; color_index = base in NORMAL, 3'd7 in FLASH.
REQ-016 SHALL count frame_start pulses in NORMAL with a frame counter of width ceil(log2(AUTO_FRAMES)); auto_tick = auto_en and counter == AUTO_FRAMES-1.
REQ-017 SHALL, at frame_start in NORMAL with hold=0 and both pending flags set (corner hit): advance base once, enter FLASH, load flash counter with FLASH_FRAMES, clear frame counter and both flags.
REQ-018 SHALL, at frame_start in NORMAL with hold=0 and exactly one flag set or auto_tick: advance base exactly once (never twice when bounce and auto_tick coincide), clear frame counter and flags.
REQ-019 SHALL, at frame_start in NORMAL with no event, increment frame counter, wrapping to 0 after AUTO_FRAMES-1; when auto_en=0 the counter holds at 0.
REQ-020 SHALL, at frame_start with hold=1: make no base or state change, retain pending flags, hold frame counter.
REQ-021 SHALL in FLASH discard bounce pulses, hold frame counter, decrement flash counter per frame_start (hold ignored), return to NORMAL on the frame_start where counter reaches 0.
REQ-022 SHALL register all updates in the frame_start cycle; new color_index visible the following cycle (latency 1).
REQ-023 SHALL pulse changed for exactly one cycle, aligned with the first cycle color_index shows a new value.
REQ-024 SHALL never change color_index outside the cycle following a frame_start.

Reset
REQ-025 SHALL on reset=1 at a clk edge set: state NORMAL, base 0, color_index 0, changed 0, pend_x/pend_y 0, frame and flash counters 0.
REQ-026 SHALL give reset priority over every input, including frame_start and bounces in the same cycle.
REQ-027 SHALL abort FLASH on reset mid-flash, returning to NORMAL with base 0.

Structure
REQ-028 SHALL place state encodings (NORMAL=0, FLASH=1) and FLASH_INDEX=3'd7 in shared package color_pkg.
REQ-029 SHALL use one sub-module, frame_timer: parameterised modulo-N frame_start counter with enable, clear and terminal-count output, providing auto_tick.
REQ-030 SHALL keep the palette lookup external; this block outputs the index only.

Verification
REQ-031 Reset, then bounce_x at cycle 10, frame_start at cycle 20 -> color_index 0->1 at cycle 21, changed=1 at cycle 21 only.
REQ-032 bounce_x and bounce_y between frame_starts, FLASH_FRAMES=8 -> color_index=7 after next frame_start for 8 frames, then base 1; bounces during flash have no effect.
REQ-033 auto_en=1, AUTO_FRAMES=4, no bounces, base=7 -> advances every 4th frame_start, 7 wraps to 0.
REQ-034 auto_tick frame_start coinciding with bounce_y -> base advances by exactly 1; frame counter restarts at 0.
REQ-035 hold=1 with bounce_x pending over 3 frame_starts -> no change; hold released -> advance at next frame_start.
REQ-036 reset asserted in FLASH with frame_start and bounce_x same cycle -> next cycle NORMAL, color_index 0, changed 0, flags clear.

Source files
------------

// File: rtl/color_pkg.sv
// ============================================================================
// color_pkg : shared state encodings and palette constants for color_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package color_pkg;

    localparam logic [0:0] ST_NORMAL   = 1'b0;
    localparam logic [0:0] ST_FLASH    = 1'b1;
    localparam logic [2:0] FLASH_INDEX = 3'd7;

    function automatic logic [2:0] next_index(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ============================================================================
// frame_timer : modulo-N frame_start counter with enable, clear, terminal count
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_timer #(
    parameter int N = 60,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/color_sequencer.sv
// ============================================================================
// color_sequencer : picks the palette index from bounce, corner and auto events
// Rev 1.0
// ============================================================================
`default_nettype none

module color_sequencer
    import color_pkg::*;
#(
    parameter int AUTO_FRAMES  = 60,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       bounce_x,
    input  logic       bounce_y,
    input  logic       auto_en,
    input  logic       hold,
    output logic [2:0] color_index,
    output logic       changed
);

    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

    logic [0:0] state_q, state_d;
    logic [2:0] base_q, base_d;
    logic       pend_x_q, pend_x_d;
    logic       pend_y_q, pend_y_d;
    logic [7:0] flash_q, flash_d;
    logic [2:0] color_index_q, color_index_d;
    logic       changed_q, changed_d;

    logic eff_x, eff_y, corner, single;
    logic timer_tc, auto_tick, timer_en, timer_clr;

    // Same-cycle bounces count toward the frame_start being processed
    assign eff_x     = pend_x_q | bounce_x;
    assign eff_y     = pend_y_q | bounce_y;
    assign auto_tick = auto_en & timer_tc;
    assign corner    = eff_x & eff_y;
    assign single    = (eff_x ^ eff_y) | auto_tick;

    assign timer_en  = frame_start & (state_q == ST_NORMAL) & ~hold;
    assign timer_clr = timer_en & (eff_x | eff_y | auto_tick | ~auto_en);

    frame_timer #(
        .N (AUTO_FRAMES)
    ) u_frame_timer (
        .clk   (clk),
        .reset (reset),
        .en_i  (timer_en),
        .clr_i (timer_clr),
        .tc_o  (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_NORMAL;
            base_q        <= 3'd0;
            pend_x_q      <= 1'b0;
            pend_y_q      <= 1'b0;
            flash_q       <= 8'd0;
            color_index_q <= 3'd0;
            changed_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            flash_q       <= flash_d;
            color_index_q <= color_index_d;
            changed_q     <= changed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        flash_d  = flash_q;
        if (state_q == ST_NORMAL) begin
            if (frame_start && !hold) begin
                pend_x_d = 1'b0;
                pend_y_d = 1'b0;
                if (corner) begin
                    base_d  = next_index(base_q);
                    state_d = ST_FLASH;
                    flash_d = FLASH_LOAD;
                end else if (single) begin
                    base_d = next_index(base_q);
                end
            end else begin
                pend_x_d = eff_x;
                pend_y_d = eff_y;
            end
        end else begin
            // Bounces are discarded while flashing; hold has no effect here
            pend_x_d = 1'b0;
            pend_y_d = 1'b0;
            if (frame_start) begin
                if (flash_q <= 8'd1) begin
                    flash_d = 8'd0;
                    state_d = ST_NORMAL;
                end else begin
                    flash_d = flash_q - 8'd1;
                end
            end
        end
    end

    always_comb begin
        color_index_d = (state_d == ST_FLASH) ? FLASH_INDEX : base_d;
        changed_d     = (color_index_d != color_index_q);
    end

    assign color_index = color_index_q;
    assign changed     = changed_q;

endmodule

`default_nettype wire
